// File: rtl/pc_pkg.sv
// Shared program-counter constants and the branch-target alignment mask helper,
// used by the fetch PC generator and by decode branch-target logic.
package pc_pkg;

    localparam int DEFAULT_ADDR_W   = 16;
    localparam int DEFAULT_INC      = 2;
    localparam int DEFAULT_RESET_PC = 0;

    // Mask covering the addr_w-bit PC with the low log2(inc) bits cleared;
    // callers truncate to their own width.
    function automatic logic [63:0] align_mask(input int addr_w, input int inc);
        logic [63:0] m;
        int          align;
        align = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(inc)) begin
                align = i + 1;
            end
        end
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < addr_w && i >= align) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect target that arrived while fetch was stalled until the stall
// releases; a newer capture overwrites an older one.
module pc_redirect_latch #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              drain,
    input  logic [ADDR_W-1:0] capture_target,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_target
);

    logic              pend_valid_reg;
    logic              pend_valid_next;
    logic [ADDR_W-1:0] pend_target_reg;
    logic [ADDR_W-1:0] pend_target_next;

    always_comb begin
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        if (capture) begin
            pend_valid_next  = 1'b1;
            pend_target_next = capture_target;
        end else if (drain) begin
            // Target is left as-is; only the valid bit matters once drained.
            pend_valid_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
        end
    end

    assign pend_valid  = pend_valid_reg;
    assign pend_target = pend_target_reg;

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: sequential increment, stall hold, branch/jump
// redirect (including redirects deferred across a stall) and flush generation.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter int                INC          = DEFAULT_INC,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_inc,
    output logic              flush,
    output logic              redirect_pending,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(ADDR_W, INC));
    localparam logic [3:0]        FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [3:0]        flush_cnt_reg;
    logic [3:0]        flush_cnt_next;
    logic              misalign_reg;
    logic              misalign_next;
    logic              load_redirect;

    logic [ADDR_W-1:0] aligned_target;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    assign aligned_target = br_target & ALIGN_MASK;
    assign pc_plus_inc    = pc_reg + ADDR_W'(INC);

    pc_redirect_latch #(
        .ADDR_W(ADDR_W)
    ) u_redirect_latch (
        .clk           (clk),
        .rst           (rst),
        .capture       (hazard_stall & br_taken),
        .drain         (~hazard_stall),
        .capture_target(aligned_target),
        .pend_valid    (pend_valid),
        .pend_target   (pend_target)
    );

    // A live redirect beats a pending one; both are ignored while stalled.
    always_comb begin
        pc_next       = pc_plus_inc;
        load_redirect = 1'b0;
        if (hazard_stall) begin
            pc_next = pc_reg;
        end else if (br_taken) begin
            pc_next       = aligned_target;
            load_redirect = 1'b1;
        end else if (pend_valid) begin
            pc_next       = pend_target;
            load_redirect = 1'b1;
        end
    end

    always_comb begin
        flush_cnt_next = flush_cnt_reg;
        if (load_redirect) begin
            flush_cnt_next = FLUSH_LOAD;
        end else if (flush_cnt_reg != 4'd0) begin
            flush_cnt_next = flush_cnt_reg - 4'd1;
        end
    end

    // Flagged for every request, latched or applied.
    assign misalign_next = br_taken && ((br_target & ~ALIGN_MASK) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            flush_cnt_reg <= 4'd0;
            misalign_reg  <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            flush_cnt_reg <= flush_cnt_next;
            misalign_reg  <= misalign_next;
        end
    end

    assign pc               = pc_reg;
    assign flush            = (flush_cnt_reg != 4'd0);
    assign redirect_pending = pend_valid;
    assign misalign_err     = misalign_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit: stimulus pushes the hand-computed
// post-edge state into a queue, a monitor pops and compares after each edge.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] pc;
    logic [15:0] pc_plus_inc;
    logic        flush;
    logic        redirect_pending;
    logic        misalign_err;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        flush;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    always #5 clk = ~clk;

    pc_next_unit dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_stall    (hazard_stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .pc              (pc),
        .pc_plus_inc     (pc_plus_inc),
        .flush           (flush),
        .redirect_pending(redirect_pending),
        .misalign_err    (misalign_err)
    );

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "pc", pc, e.pc);
            check(e.name, "pc_plus_inc", pc_plus_inc, e.pc + 16'd2);
            check(e.name, "flush", 16'(flush), 16'(e.flush));
            check(e.name, "redirect_pending", 16'(redirect_pending), 16'(e.pend));
            check(e.name, "misalign_err", 16'(misalign_err), 16'(e.mis));
            n_txn++;
            $display("[TB] txn %0d %s: pc=%h flush=%0b pend=%0b mis=%0b", n_txn, e.name,
                     pc, flush, redirect_pending, misalign_err);
        end
    end

    task automatic step(input string name, input logic r, input logic st,
                        input logic bt, input logic [15:0] tgt,
                        input logic [15:0] e_pc, input logic e_fl,
                        input logic e_pd, input logic e_mi);
        exp_t e;
        @(negedge clk);
        rst          = r;
        hazard_stall = st;
        br_taken     = bt;
        br_target    = tgt;
        e.name  = name;
        e.pc    = e_pc;
        e.flush = e_fl;
        e.pend  = e_pd;
        e.mis   = e_mi;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout pending=%0d required=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        //    name          rst st  bt  target    pc        fl  pd  mi
        step("reset0",      1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step("reset1",      1, 1, 1, 16'h0123, 16'h0000, 0, 0, 0);
        step("run1",        0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0);
        step("run2",        0, 0, 0, 16'h0000, 16'h0004, 0, 0, 0);
        step("run3",        0, 0, 0, 16'h0000, 16'h0006, 0, 0, 0);
        step("run4",        0, 0, 0, 16'h0000, 16'h0008, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("run_to_10", 0, 0, 0, 16'h0000, 16'h000A + 16'(2 * i), 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall",   0, 1, 0, 16'h0000, 16'h0010, 0, 0, 0);
        step("unstall",     0, 0, 0, 16'h0000, 16'h0012, 0, 0, 0);
        step("branch",      0, 0, 1, 16'h0100, 16'h0100, 1, 0, 0);
        step("post_br",     0, 0, 0, 16'h0000, 16'h0102, 0, 0, 0);
        step("stall_br40",  0, 1, 1, 16'h0040, 16'h0102, 0, 1, 0);
        step("stall_br80",  0, 1, 1, 16'h0080, 16'h0102, 0, 1, 0);
        step("stall_hold1", 0, 1, 0, 16'h0000, 16'h0102, 0, 1, 0);
        step("stall_hold2", 0, 1, 0, 16'h0000, 16'h0102, 0, 1, 0);
        step("release",     0, 0, 0, 16'h0000, 16'h0080, 1, 0, 0);
        step("post_rel",    0, 0, 0, 16'h0000, 16'h0082, 0, 0, 0);
        step("misalign",    0, 0, 1, 16'h0105, 16'h0104, 1, 0, 1);
        step("post_mis",    0, 0, 0, 16'h0000, 16'h0106, 0, 0, 0);
        step("br_fffc",     0, 0, 1, 16'hFFFC, 16'hFFFC, 1, 0, 0);
        step("to_fffe",     0, 0, 0, 16'h0000, 16'hFFFE, 0, 0, 0);
        step("wrap",        0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step("post_wrap",   0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0);
        step("stall_mis",   0, 1, 1, 16'h0203, 16'h0002, 0, 1, 1);
        step("rst_pend",    1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        step("post_rst1",   0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0);
        step("post_rst2",   0, 0, 0, 16'h0000, 16'h0004, 0, 0, 0);
        step("stall_br300", 0, 1, 1, 16'h0300, 16'h0004, 0, 1, 0);
        step("live_beats",  0, 0, 1, 16'h0400, 16'h0400, 1, 0, 0);
        step("post_live",   0, 0, 0, 16'h0000, 16'h0402, 0, 0, 0);
        step("br_again",    0, 0, 1, 16'h0010, 16'h0010, 1, 0, 0);
        step("br_in_flush", 0, 0, 1, 16'h0020, 16'h0020, 1, 0, 0);
        step("flush_done",  0, 0, 0, 16'h0000, 16'h0022, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; hazard_stall = 1'b0; br_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue_left=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter generator for the 16-bit datapath: owns the PC register and selects each cycle between sequential increment, hold on hazard stall, and redirect to a branch/jump target. Generalises the fixed stall/increment selector with parametrised width and increment, a pending-redirect latch for redirects that arrive during a stall, a pipeline flush pulse, and target alignment checking. Sits at the head of the fetch stage and drives the instruction-memory address and the PC+INC value forwarded to decode.

## Interface
- ADDR_W, 16, PC width in bits
- INC, 2, sequential increment; power of two, 1..2^(ADDR_W-1)
- RESET_PC, 0, PC value loaded by reset
- FLUSH_CYCLES, 1, cycles `flush` stays high after a redirect is applied (1..15)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- hazard_stall  in  1  hold PC this cycle
- br_taken  in  1  redirect request, one-cycle qualifier for br_target
- br_target  in  ADDR_W  redirect target address
- pc  out  ADDR_W  current PC (registered)
- pc_plus_inc  out  ADDR_W  pc + INC, combinational, modulo 2^ADDR_W
- flush  out  1  squash younger fetched instructions (registered)
- redirect_pending  out  1  a redirect is latched, waiting for stall release (registered)
- misalign_err  out  1  one-cycle pulse: accepted target had nonzero low bits (registered)

## Operation
- ALIGN = log2(INC). Aligned target = br_target with low ALIGN bits cleared; no clearing when INC = 1.
- State: pc, pend_valid, pend_target, flush_cnt (4 bits), misalign_err flop.
- Priority on each rising edge, rst not asserted:
  - hazard_stall=1, br_taken=1: pc holds; pend_valid<=1, pend_target<=aligned target (newest request overwrites any older pending one).
  - hazard_stall=1, br_taken=0: pc and pending state hold.
  - hazard_stall=0, br_taken=1: pc<=aligned target; pend_valid<=0 (live request beats pending).
  - hazard_stall=0, pend_valid=1: pc<=pend_target; pend_valid<=0.
  - otherwise: pc<=pc+INC, wrapping modulo 2^ADDR_W (0xFFFE+2 -> 0x0000 at default).
- Applying a redirect (either of the two load cases) sets flush_cnt<=FLUSH_CYCLES; otherwise flush_cnt decrements toward 0 every cycle, stalled or not. flush = (flush_cnt != 0).
- misalign_err<=1 on any edge where br_taken=1 and br_target low ALIGN bits != 0 (whether latched or applied); else 0.
- redirect_pending = pend_valid.

## Timing
- Reset: pc=RESET_PC, pend_valid=0, pend_target=0, flush_cnt=0, flush=0, redirect_pending=0, misalign_err=0; pc_plus_inc=RESET_PC+INC. Reset overrides all other inputs that cycle; a pending redirect is discarded.
- Redirect latency: br_taken sampled at edge N, pc=target after edge N, flush high for cycles N+1..N+FLUSH_CYCLES.
- Stalled redirect: applied on first edge with hazard_stall=0; redirect_pending falls on that same edge.
- Redirect while flush active: counter reloads to FLUSH_CYCLES.
- br_taken only meaningful for one cycle; a held br_taken is treated as repeated requests to the same target.

## Structure
- Shared package pc_pkg: default ADDR_W, INC, RESET_PC constants and an align-mask function of (ADDR_W, INC); reused by decode branch-target logic.
- One sub-module natural: pc_redirect_latch (pend_valid/pend_target capture, overwrite and clear). Increment, priority select and flush counter stay in pc_next_unit.

## Test plan
- Reset then 4 free-run cycles -> pc 0x0000, 0x0002, 0x0004, 0x0006, 0x0008; flush, redirect_pending, misalign_err all 0.
- pc=0x0010, hazard_stall high 3 cycles -> pc stays 0x0010 for 3 cycles, then 0x0012.
- br_taken with target 0x0100 while unstalled -> pc=0x0100 next cycle, flush high exactly FLUSH_CYCLES (1) cycle.
- Stall high, br_taken 0x0040 then br_taken 0x0080 on next cycle, stall released 2 cycles later -> redirect_pending high, pc=0x0080 on release edge, 0x0040 never appears.
- br_target 0x0105 -> pc=0x0104, misalign_err one-cycle pulse; pc=0xFFFE free-run -> 0x0000.
- Pending redirect present, rst asserted -> pc=RESET_PC, redirect_pending=0, pending target never applied.
